rv32m_muldiv_unit: RTL and testbench
====================================

RV32M_MULDIV_UNIT -- requirements
Module: rv32m_muldiv_unit

Interface
REQ-001 Parameter XLEN, default 32: operand and result width; legal values 8, 16, 32, 64.
REQ-002 Parameter TAG_W, default 5: width of the destination-register tag carried with each operation.
REQ-003 Port clk_i, input, 1: sole clock; all state updates on its rising edge.
REQ-004 Port rst_i, input, 1: reset; synchronous to clk_i and active-high.
REQ-005 Port valid_i, input, 1: request valid.
REQ-006 Port ready_o, output, 1: unit can accept a request this cycle.
REQ-007 Port op_i, input, 3: operation, encoded as funct3 of the M extension: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-008 Port a_i, input, XLEN: operand rs1.
REQ-009 Port b_i, input, XLEN: operand rs2.
REQ-010 Port tag_i, input, TAG_W: destination-register tag.
REQ-011 Port flush_i, input, 1: abort any in-flight operation, driven from the execute-stage redirect.
REQ-012 Port valid_o, output, 1: result valid.
REQ-013 Port ready_i, input, 1: consumer accepts the result.
REQ-014 Port result_o, output, XLEN: result.
REQ-015 Port tag_o, output, TAG_W: tag of the result.
REQ-016 Port busy_o, output, 1: high whenever the state is not IDLE; feeds the hazard-unit stall.

Function
REQ-017 The unit SHALL implement three states: IDLE, CALC and DONE.
REQ-018 ready_o SHALL equal (state==IDLE) and SHALL be decoded combinationally from the state register.
REQ-019 A request SHALL be accepted in a cycle when valid_i=1, ready_o=1 and flush_i=0. On acceptance the unit SHALL register op_i, a_i, b_i and tag_i; later changes on these inputs SHALL be ignored.
REQ-020 Acceptance with a normal operand pair SHALL move IDLE to CALC and clear the iteration counter to 0.
REQ-021 Multiply SHALL use iterative shift-add on the 2*XLEN-bit product, one bit per cycle.
REQ-022 Multiply operands SHALL be converted to magnitudes, with the product negated at the end when the operand signs differ:
- MULH: both operands signed.
- MULHSU: a signed, b unsigned.
- MUL and MULHU: both operands unsigned.
REQ-023 Divide SHALL use restoring division on magnitudes, one quotient bit per cycle.
REQ-024 Divide sign fix-up:
- quotient negated when the operand signs differ (signed ops only);
- remainder takes the sign of the dividend.
REQ-025 CALC SHALL last exactly XLEN cycles, then move to DONE.
- Acceptance cycle = cycle 0; valid_o first high in cycle XLEN+1.
REQ-026 Fast paths: acceptance SHALL move IDLE directly to DONE, with valid_o high in cycle 1, when:
- the divisor is 0 (DIV, DIVU, REM, REMU), or
- signed overflow occurs (DIV or REM, a = -2^(XLEN-1), b = -1).
REQ-027 Divide-by-zero results: quotient all ones; remainder = a.
REQ-028 Signed-overflow results: quotient = a; remainder = 0.
REQ-029 result_o bits by operation:
- MUL: product bits [XLEN-1:0].
- MULH, MULHSU, MULHU: product bits [2*XLEN-1:XLEN].
- DIV, DIVU: quotient.
- REM, REMU: remainder.
REQ-030 In DONE, valid_o SHALL be 1, and result_o and tag_o SHALL be held stable until ready_i=1.
REQ-031 DONE with ready_i=1 SHALL return to IDLE in the next cycle. A new request SHALL NOT be accepted in that same DONE cycle.
REQ-032 flush_i=1 in CALC or DONE SHALL force IDLE on the next edge with no valid_o pulse; flush SHALL win over ready_i in the same cycle.
REQ-033 flush_i=1 in IDLE SHALL block acceptance even if valid_i=1.
REQ-034 valid_o SHALL be 0 in IDLE and CALC.
REQ-035 In IDLE and CALC, result_o and tag_o SHALL be 0.

Reset
REQ-036 When rst_i=1 at a clock edge, the unit SHALL enter IDLE with the following register values:
- iteration counter 0;
- operand, result and tag registers 0;
- valid_o=0, busy_o=0, result_o=0, tag_o=0;
- ready_o=1 from the first cycle after reset.
REQ-037 Reset SHALL take priority over flush_i, valid_i and ready_i.
REQ-038 Reset asserted mid-CALC or in DONE SHALL discard the operation with no valid_o pulse.

Verification
REQ-039 XLEN=32, MULHSU, a=0xFFFFFFFF, b=0x00000002, tag=7 -> valid_o in cycle 33, result_o=0xFFFFFFFF, tag_o=7.
REQ-040 XLEN=32:
- DIV, a=0xFFFFFFF9 (-7), b=2 -> result_o=0xFFFFFFFD (-3);
- REM with the same operands -> result_o=0xFFFFFFFF (-1);
- both valid in cycle 33.
REQ-041 XLEN=32 edge cases, each with valid_o in cycle 1:
- DIVU, b=0, a=0x12345678 -> result_o=0xFFFFFFFF;
- REM, a=0x80000000, b=0xFFFFFFFF -> result_o=0.
REQ-042 XLEN=32, MUL 3*5 accepted, flush_i pulsed in cycle 10 -> busy_o=0 from cycle 11, valid_o never rises; MUL 6*7 then accepted in cycle 11 -> result_o=42 in cycle 44.
REQ-043 XLEN=32, ready_i held 0 for 5 cycles after valid_o rises -> result_o and tag_o stable throughout, ready_o=0 throughout; ready_i=1 -> IDLE next cycle.
REQ-044 XLEN=8, MULHU, 0xFF*0xFF -> result_o=0xFE in cycle 9; then rst_i asserted in cycle 4 of the next operation -> valid_o stays 0, busy_o=0 and ready_o=1 afterwards.

Source files
------------

// File: rtl/rv32m_muldiv_unit.sv
// RV32M multiply/divide unit: iterative shift-add multiplier and restoring
// divider sharing one operand datapath, one bit per cycle, tagged result
// handshake with flush support and single-cycle fast paths for divide by zero
// and signed divide overflow.
module rv32m_muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [2:0]       op_i,
  input  logic [XLEN-1:0]  a_i,
  input  logic [XLEN-1:0]  b_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic             flush_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [XLEN-1:0]  result_o,
  output logic [TAG_W-1:0] tag_o,
  output logic             busy_o
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Operation context captured at acceptance
  logic [2:0]       r_op;
  logic [TAG_W-1:0] r_tag;
  logic             r_neg_q;   // negate product / quotient at the end
  logic             r_neg_r;   // negate remainder at the end (dividend sign)
  logic [CNT_W-1:0] r_cnt;

  // Shared iteration registers:
  //   multiply: {r_hi, r_lo} is the partial product, r_lo initially holds the
  //             multiplier magnitude, r_mag_b is the multiplicand magnitude.
  //   divide:   r_hi is the partial remainder, r_lo shifts the dividend out
  //             and the quotient in, r_mag_b is the divisor magnitude.
  logic [XLEN-1:0]  r_hi;
  logic [XLEN-1:0]  r_lo;
  logic [XLEN-1:0]  r_mag_b;
  logic [XLEN-1:0]  r_result;

  // ---------------- request decode ----------------
  logic            w_accept;
  logic            w_in_div;
  logic            w_in_sdiv;
  logic            w_a_signed;
  logic            w_b_signed;
  logic            w_a_neg;
  logic            w_b_neg;
  logic            w_b_zero;
  logic            w_ovf;
  logic            w_fast;
  logic [XLEN-1:0] w_fast_result;
  logic [XLEN-1:0] w_mag_a;
  logic [XLEN-1:0] w_mag_b;

  assign w_accept   = valid_i && (r_state == S_IDLE) && !flush_i;
  assign w_in_div   = op_i[2];
  assign w_in_sdiv  = op_i[2] & ~op_i[0];           // DIV, REM
  assign w_a_signed = w_in_div ? w_in_sdiv : ((op_i == 3'd1) || (op_i == 3'd2));
  assign w_b_signed = w_in_div ? w_in_sdiv : (op_i == 3'd1);
  assign w_a_neg    = w_a_signed & a_i[XLEN-1];
  assign w_b_neg    = w_b_signed & b_i[XLEN-1];
  assign w_mag_a    = w_a_neg ? -a_i : a_i;
  assign w_mag_b    = w_b_neg ? -b_i : b_i;
  assign w_b_zero   = (b_i == '0);
  assign w_ovf      = w_in_sdiv && (a_i == MIN_NEG) && (b_i == '1);
  assign w_fast     = w_in_div && (w_b_zero || w_ovf);

  // Fast-path results; op_i[1] selects remainder over quotient
  always_comb begin
    w_fast_result = '0;
    if (w_b_zero) begin
      w_fast_result = op_i[1] ? a_i : '1;
    end else if (w_ovf) begin
      w_fast_result = op_i[1] ? '0 : a_i;
    end
  end

  // ---------------- iteration step ----------------
  logic [XLEN:0]     w_madd;
  logic [2*XLEN-1:0] w_prod;
  logic [2*XLEN-1:0] w_prod_fix;
  logic [XLEN:0]     w_rsh;
  logic              w_div_ok;
  logic [XLEN-1:0]   w_sub;
  logic [XLEN-1:0]   w_rem_step;
  logic [XLEN-1:0]   w_quo_step;
  logic [XLEN-1:0]   w_rem_fix;
  logic [XLEN-1:0]   w_quo_fix;
  logic [XLEN-1:0]   w_hi_next;
  logic [XLEN-1:0]   w_lo_next;
  logic [XLEN-1:0]   w_final;

  // Multiply: add multiplicand into the high half when the multiplier LSB is
  // set, then shift the whole product right by one.
  assign w_madd     = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mag_b} : {(XLEN+1){1'b0}});
  assign w_prod     = {w_madd, r_lo[XLEN-1:1]};
  assign w_prod_fix = r_neg_q ? -w_prod : w_prod;

  // Divide: shift in the next dividend bit, subtract the divisor if it fits.
  // The difference is always below the divisor, so XLEN bits suffice.
  assign w_rsh      = {r_hi, r_lo[XLEN-1]};
  assign w_div_ok   = (w_rsh >= {1'b0, r_mag_b});
  assign w_sub      = w_rsh[XLEN-1:0] - r_mag_b;
  assign w_rem_step = w_div_ok ? w_sub : w_rsh[XLEN-1:0];
  assign w_quo_step = {r_lo[XLEN-2:0], w_div_ok};
  assign w_quo_fix  = r_neg_q ? -w_quo_step : w_quo_step;
  assign w_rem_fix  = r_neg_r ? -w_rem_step : w_rem_step;

  assign w_hi_next  = r_op[2] ? w_rem_step : w_prod[2*XLEN-1:XLEN];
  assign w_lo_next  = r_op[2] ? w_quo_step : w_prod[XLEN-1:0];

  // Result selection from the final iteration, sign-corrected
  always_comb begin
    w_final = '0;
    case (r_op)
      3'd0:                w_final = w_prod_fix[XLEN-1:0];
      3'd1, 3'd2, 3'd3:    w_final = w_prod_fix[2*XLEN-1:XLEN];
      3'd4, 3'd5:          w_final = w_quo_fix;
      default:             w_final = w_rem_fix;
    endcase
  end

  // ---------------- FSM ----------------
  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode; flush beats result acceptance
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_next = w_fast ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        if (flush_i) begin
          w_state_next = S_IDLE;
        end else if (r_cnt == LAST_CNT) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        if (flush_i || ready_i) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Datapath: capture on acceptance, one iteration per CALC cycle
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_op     <= '0;
      r_tag    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_mag_b  <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op     <= op_i;
            r_tag    <= tag_i;
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= w_mag_a;
            r_mag_b  <= w_mag_b;
            r_result <= w_fast ? w_fast_result : '0;
          end
        end
        S_CALC: begin
          r_cnt <= r_cnt + CNT_W'(1);
          r_hi  <= w_hi_next;
          r_lo  <= w_lo_next;
          if (r_cnt == LAST_CNT) begin
            r_result <= w_final;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // ---------------- outputs ----------------
  assign ready_o  = (r_state == S_IDLE);
  assign valid_o  = (r_state == S_DONE);
  assign busy_o   = (r_state != S_IDLE);
  assign result_o = valid_o ? r_result : '0;
  assign tag_o    = valid_o ? r_tag : '0;

endmodule

// File: tb/tb_rv32m_muldiv_unit.sv
// Bench for rv32m_muldiv_unit: directed vector table, random operations
// against a plain-arithmetic reference model, and hand-written sequences for
// flush, stall, reset and the 8-bit configuration.
module tb_rv32m_muldiv_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 32-bit instance signals
  logic        rst_i, valid_i, flush_i, ready_i;
  logic [2:0]  op_i;
  logic [31:0] a_i, b_i;
  logic [4:0]  tag_i;
  logic        ready_o, valid_o, busy_o;
  logic [31:0] result_o;
  logic [4:0]  tag_o;

  // 8-bit instance signals
  logic        rst8, valid8, flush8, ready8;
  logic [2:0]  op8;
  logic [7:0]  a8, b8;
  logic [4:0]  tagi8;
  logic        ready_o8, valid_o8, busy_o8;
  logic [7:0]  result8;
  logic [4:0]  tago8;

  rv32m_muldiv_unit #(.XLEN(32), .TAG_W(5)) dut (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .op_i(op_i), .a_i(a_i), .b_i(b_i), .tag_i(tag_i), .flush_i(flush_i),
    .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o),
    .tag_o(tag_o), .busy_o(busy_o)
  );

  rv32m_muldiv_unit #(.XLEN(8), .TAG_W(5)) dut8 (
    .clk_i(clk), .rst_i(rst8), .valid_i(valid8), .ready_o(ready_o8),
    .op_i(op8), .a_i(a8), .b_i(b8), .tag_i(tagi8), .flush_i(flush8),
    .valid_o(valid_o8), .ready_i(ready8), .result_o(result8),
    .tag_o(tago8), .busy_o(busy_o8)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Reference model: the M-extension rules in plain wide arithmetic
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb;
    logic [63:0] ua, ub, p;
    int ia, ib;
    logic ovf;
    ua = {32'd0, a};
    ub = {32'd0, b};
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ia = a;
    ib = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    model = '0;
    case (op)
      3'd0: begin p = ua * ub; model = p[31:0]; end
      3'd1: begin p = sa * sb; model = p[63:32]; end
      3'd2: begin p = sa * ub; model = p[63:32]; end
      3'd3: begin p = ua * ub; model = p[63:32]; end
      3'd4: model = (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'(ia / ib));
      3'd5: model = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: model = (b == 0) ? a : (ovf ? 32'd0 : 32'(ia % ib));
      default: model = (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic fast;
    fast = op[2] && ((b == 0) ||
           (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    model_lat = fast ? 1 : 33;
  endfunction

  // Issue one request, scramble inputs afterwards, wait for the result
  // (bounded), then consume it. lat is the cycle index of the first valid_o.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, output logic [31:0] res,
                        output logic [4:0] tg, output int lat);
    @(negedge clk);
    valid_i = 1'b1; op_i = op; a_i = a; b_i = b; tag_i = tag;
    @(posedge clk); #1;
    valid_i = 1'b0; op_i = 3'($urandom); a_i = $urandom; b_i = $urandom; tag_i = 5'($urandom);
    lat = 1;
    while (!valid_o && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    res = result_o;
    tg  = tag_o;
    ready_i = 1'b1;
    @(posedge clk); #1;
    ready_i = 1'b0;
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  tag;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[16];

  initial begin
    logic [31:0] res, ra, rb;
    logic [4:0]  tg, rt;
    logic [2:0]  rop;
    int lat, cyc;
    logic seen, stable;

    vecs[0]  = '{3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 5'd7,  32'hFFFF_FFFF, 33};
    vecs[1]  = '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 5'd3,  32'hFFFF_FFFD, 33};
    vecs[2]  = '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 5'd4,  32'hFFFF_FFFF, 33};
    vecs[3]  = '{3'd5, 32'h1234_5678, 32'h0000_0000, 5'd5,  32'hFFFF_FFFF, 1};
    vecs[4]  = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6,  32'h0000_0000, 1};
    vecs[5]  = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8,  32'h8000_0000, 1};
    vecs[6]  = '{3'd7, 32'h1234_5678, 32'h0000_0000, 5'd9,  32'h1234_5678, 1};
    vecs[7]  = '{3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10, 32'h0000_0001, 33};
    vecs[8]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 5'd11, 32'h4000_0000, 33};
    vecs[9]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd12, 32'hFFFF_FFFE, 33};
    vecs[10] = '{3'd5, 32'hFFFF_FFFF, 32'h0000_000A, 5'd13, 32'h1999_9999, 33};
    vecs[11] = '{3'd6, 32'h0000_0007, 32'hFFFF_FFFE, 5'd14, 32'h0000_0001, 33};
    vecs[12] = '{3'd4, 32'h0000_0000, 32'h0000_0000, 5'd15, 32'hFFFF_FFFF, 1};
    vecs[13] = '{3'd1, 32'hFFFF_FFFF, 32'h0000_0001, 5'd31, 32'hFFFF_FFFF, 33};
    vecs[14] = '{3'd6, 32'hFFFF_FFF9, 32'h0000_0000, 5'd16, 32'hFFFF_FFF9, 1};
    vecs[15] = '{3'd4, 32'h0000_0007, 32'hFFFF_FFFE, 5'd17, 32'hFFFF_FFFD, 33};

    rst_i = 1'b1; valid_i = 1'b0; flush_i = 1'b0; ready_i = 1'b0;
    op_i = '0; a_i = '0; b_i = '0; tag_i = '0;
    rst8 = 1'b1; valid8 = 1'b0; flush8 = 1'b0; ready8 = 1'b0;
    op8 = '0; a8 = '0; b8 = '0; tagi8 = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b0; rst8 = 1'b0;

    // Reset state
    chk("reset_ready",  ready_o,  1'b1);
    chk("reset_valid",  valid_o,  1'b0);
    chk("reset_busy",   busy_o,   1'b0);
    chk("reset_result", result_o, 32'd0);
    chk("reset_tag",    tag_o,    5'd0);
    chk("reset8_ready", ready_o8, 1'b1);

    // Directed vector table
    for (int i = 0; i < 16; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag, res, tg, lat);
      $display("vec %0d op=%0d a=%h b=%h -> result=%h tag=%0d cycle=%0d",
               i, vecs[i].op, vecs[i].a, vecs[i].b, res, tg, lat);
      chk($sformatf("vec%0d_result", i), res, vecs[i].exp);
      chk($sformatf("vec%0d_tag", i), tg, vecs[i].tag);
      chk($sformatf("vec%0d_cycle", i), lat, vecs[i].lat);
    end

    // Random operations against the reference model
    for (int i = 0; i < 60; i++) begin
      rop = 3'($urandom);
      ra  = $urandom;
      rb  = $urandom;
      rt  = 5'($urandom);
      case ($urandom_range(0, 9))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 20));
        3: rb = -32'($urandom_range(1, 20));
        default: ;
      endcase
      run_op(rop, ra, rb, rt, res, tg, lat);
      $display("rnd %0d op=%0d a=%h b=%h -> result=%h tag=%0d cycle=%0d",
               i, rop, ra, rb, res, tg, lat);
      chk($sformatf("rnd%0d_result", i), res, model(rop, ra, rb));
      chk($sformatf("rnd%0d_tag", i), tg, rt);
      chk($sformatf("rnd%0d_cycle", i), lat, model_lat(rop, ra, rb));
    end

    // Flush mid-CALC, then a fresh multiply in the cycle after the flush
    @(negedge clk);
    valid_i = 1'b1; op_i = 3'd0; a_i = 32'd3; b_i = 32'd5; tag_i = 5'd1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    cyc = 1; seen = 1'b0;
    while (cyc < 10) begin
      if (valid_o) seen = 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    chk("flush_busy_before", busy_o, 1'b1);
    flush_i = 1'b1;
    @(posedge clk); #1;
    cyc++;
    flush_i = 1'b0;
    chk("flush_busy_after",  busy_o,  1'b0);
    chk("flush_ready_after", ready_o, 1'b1);
    valid_i = 1'b1; op_i = 3'd0; a_i = 32'd6; b_i = 32'd7; tag_i = 5'd2;
    @(posedge clk); #1;
    cyc++;
    valid_i = 1'b0;
    while (cyc < 44) begin
      if (valid_o) seen = 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    $display("flush seq: cycle=%0d valid=%0d result=%0d", cyc, valid_o, result_o);
    chk("flush_no_early_valid", seen, 1'b0);
    chk("flush_valid_c44", valid_o, 1'b1);
    chk("flush_result_c44", result_o, 32'd42);
    chk("flush_tag_c44", tag_o, 5'd2);
    ready_i = 1'b1;
    @(posedge clk); #1;
    ready_i = 1'b0;

    // Back-pressure: hold result for 5 cycles, then release with a request
    // offered in the same DONE cycle (must not be taken)
    @(negedge clk);
    valid_i = 1'b1; op_i = 3'd1; a_i = 32'hDEAD_BEEF; b_i = 32'h1234_5678; tag_i = 5'd21;
    @(posedge clk); #1;
    valid_i = 1'b0; a_i = 32'd0; b_i = 32'd0;
    lat = 1;
    while (!valid_o && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    res = result_o; tg = tag_o; stable = 1'b1;
    chk("stall_result", res, model(3'd1, 32'hDEAD_BEEF, 32'h1234_5678));
    chk("stall_tag", tg, 5'd21);
    for (int k = 0; k < 5; k++) begin
      if (result_o !== res || tag_o !== tg || ready_o !== 1'b0 || valid_o !== 1'b1)
        stable = 1'b0;
      @(posedge clk); #1;
    end
    $display("stall seq: result=%h tag=%0d held=%0d", res, tg, stable);
    chk("stall_held", stable, 1'b1);
    ready_i = 1'b1;
    valid_i = 1'b1; op_i = 3'd0; a_i = 32'd9; b_i = 32'd9; tag_i = 5'd3;
    @(posedge clk); #1;
    ready_i = 1'b0; valid_i = 1'b0;
    chk("release_valid", valid_o, 1'b0);
    chk("release_ready", ready_o, 1'b1);
    chk("release_no_accept", busy_o, 1'b0);

    // Flush in DONE wins over ready_i
    @(negedge clk);
    valid_i = 1'b1; op_i = 3'd5; a_i = 32'd1; b_i = 32'd0; tag_i = 5'd4;
    @(posedge clk); #1;
    valid_i = 1'b0;
    chk("fdone_valid", valid_o, 1'b1);
    flush_i = 1'b1; ready_i = 1'b1;
    @(posedge clk); #1;
    ready_i = 1'b0;
    chk("fdone_valid_after", valid_o, 1'b0);
    chk("fdone_busy_after", busy_o, 1'b0);

    // Flush in IDLE blocks acceptance
    valid_i = 1'b1; op_i = 3'd0; a_i = 32'd2; b_i = 32'd2;
    @(posedge clk); #1;
    valid_i = 1'b0; flush_i = 1'b0;
    $display("idle flush: busy=%0d", busy_o);
    chk("fidle_busy", busy_o, 1'b0);

    // 8-bit configuration: MULHU 0xFF*0xFF
    @(negedge clk);
    valid8 = 1'b1; op8 = 3'd3; a8 = 8'hFF; b8 = 8'hFF; tagi8 = 5'd9;
    @(posedge clk); #1;
    valid8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
    lat = 1;
    while (!valid_o8 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    $display("x8 mulhu: result=%h tag=%0d cycle=%0d", result8, tago8, lat);
    chk("x8_cycle", lat, 9);
    chk("x8_result", result8, 8'hFE);
    chk("x8_tag", tago8, 5'd9);
    ready8 = 1'b1;
    @(posedge clk); #1;
    ready8 = 1'b0;

    // 8-bit: reset in cycle 4 of the next operation
    valid8 = 1'b1; op8 = 3'd0; a8 = 8'h12; b8 = 8'h34; tagi8 = 5'd5;
    @(posedge clk); #1;
    valid8 = 1'b0;
    cyc = 1; seen = 1'b0;
    while (cyc < 4) begin
      if (valid_o8) seen = 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    rst8 = 1'b1;
    @(posedge clk); #1;
    rst8 = 1'b0;
    chk("x8_rst_busy", busy_o8, 1'b0);
    chk("x8_rst_ready", ready_o8, 1'b1);
    for (int k = 0; k < 15; k++) begin
      if (valid_o8) seen = 1'b1;
      @(posedge clk); #1;
    end
    $display("x8 reset seq: valid_seen=%0d busy=%0d ready=%0d", seen, busy_o8, ready_o8);
    chk("x8_rst_no_valid", seen, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound
  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
